// File: rtl/aes_pkg.sv
// Shared AES types, the AES-128 round count, GF(2^8) xtime and the forward S-box.
// The S-box table is also used by the SubBytes stage.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    localparam int AES128_NR = 10;

    // Entry for input byte b sits at bits [(255-b)*8 +: 8]; row 0 of the usual table is the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/key_expand_step.sv
// One AES-128 key-schedule step: round key n and its rcon in, round key n+1 out.
// Purely combinational; holds the four S-box lookups of SubWord.
module key_expand_step
    import aes_pkg::*;
(
    input  state_t      rk_i,
    input  logic [7:0]  rcon_i,
    output state_t      rk_next_o
);

    word_t w0, w1, w2, w3;
    word_t rot, sub, t;
    word_t n0, n1, n2, n3;

    assign w0 = rk_i[31:0];
    assign w1 = rk_i[63:32];
    assign w2 = rk_i[95:64];
    assign w3 = rk_i[127:96];

    // Row 0 lives in the low byte, so RotWord is a one-byte right rotate here.
    assign rot = {w3[7:0], w3[31:8]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign t   = sub ^ {24'h0, rcon_i};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_next_o = {n3, n2, n1, n0};

endmodule

// File: rtl/add_round_key.sv
// AES-128 AddRoundKey with on-the-fly key schedule; 1-cycle latency, full throughput,
// in_ready drops on key_load or when the output register is full and not drained. Optional ADD_ROUND_KEY_BYPASS_EN.
module add_round_key
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef ADD_ROUND_KEY_BYPASS_EN
    input  logic         bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic [3:0]   round_out,
    output logic         last_out
);

    state_t     ck_q, ck_d;
    state_t     rk_q, rk_d;
    logic [3:0] rnd_q, rnd_d;
    logic [7:0] rcon_q, rcon_d;
    logic       key_valid_q, key_valid_d;
    logic       out_valid_q, out_valid_d;
    state_t     state_out_q, state_out_d;
    logic [3:0] round_out_q, round_out_d;
    logic       last_out_q, last_out_d;

    state_t     rk_next;
    logic       bypass_w;
    logic       accept;
    logic       last_rnd;

`ifdef ADD_ROUND_KEY_BYPASS_EN
    assign bypass_w = bypass;
`else
    assign bypass_w = 1'b0;
`endif

    key_expand_step u_key_expand_step (
        .rk_i      (rk_q),
        .rcon_i    (rcon_q),
        .rk_next_o (rk_next)
    );

    assign in_ready = key_valid_q & ~key_load & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign last_rnd = (rnd_q == 4'(NR));

    always_comb begin
        ck_d        = ck_q;
        rk_d        = rk_q;
        rnd_d       = rnd_q;
        rcon_d      = rcon_q;
        key_valid_d = key_valid_q;
        out_valid_d = out_valid_q;
        state_out_d = state_out_q;
        round_out_d = round_out_q;
        last_out_d  = last_out_q;

        // key_load forces in_ready low, so it never coincides with a schedule advance.
        if (key_load) begin
            ck_d        = key_in;
            rk_d        = key_in;
            rnd_d       = 4'd0;
            rcon_d      = 8'h01;
            key_valid_d = 1'b1;
        end else if (accept && !bypass_w) begin
            if (last_rnd) begin
                rk_d   = ck_q;
                rnd_d  = 4'd0;
                rcon_d = 8'h01;
            end else begin
                rk_d   = rk_next;
                rnd_d  = rnd_q + 4'd1;
                rcon_d = xtime(rcon_q);
            end
        end

        if (accept) begin
            out_valid_d = 1'b1;
            state_out_d = bypass_w ? state_in : (state_in ^ rk_q);
            round_out_d = rnd_q;
            last_out_d  = !bypass_w && last_rnd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= 4'd0;
            rcon_q      <= 8'h01;
            key_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            state_out_q <= '0;
            round_out_q <= 4'd0;
            last_out_q  <= 1'b0;
        end else begin
            ck_q        <= ck_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            rcon_q      <= rcon_d;
            key_valid_q <= key_valid_d;
            out_valid_q <= out_valid_d;
            state_out_q <= state_out_d;
            round_out_q <= round_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign state_out = state_out_q;
    assign round_out = round_out_q;
    assign last_out  = last_out_q;

endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key against the FIPS-197 A.1 AES-128 key schedule.
// Build with +define+ADD_ROUND_KEY_BYPASS_EN to exercise the bypass port.
module tb_add_round_key;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [3:0]   round_out;
    logic         last_out;
`ifdef ADD_ROUND_KEY_BYPASS_EN
    logic         bypass;
`endif

    int tests = 0;
    int fails = 0;

    logic [127:0] rk_tab [11];
    logic [127:0] key2;
    logic [127:0] pat1;
    logic [127:0] pat2;

    always #5 clk = ~clk;

    add_round_key dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
`ifdef ADD_ROUND_KEY_BYPASS_EN
        .bypass    (bypass),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .round_out (round_out),
        .last_out  (last_out)
    );

    // FIPS byte strings are written MSB-first; the port carries byte k at [8k +: 8].
    function automatic logic [127:0] fb(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = x[127 - 8*k -: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++;
        if ({out_valid, in_ready, last_out, round_out, state_out} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%0b r=%0b l=%0b rnd=%0d s=%h, want all zero",
                     out_valid, in_ready, last_out, round_out, state_out);
        end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_key_ready: got in_ready=%0b out_valid=%0b, want 0 0", in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fips_schedule();
        key_load = 1'b1;
        key_in   = rk_tab[0];
        out_ready = 1'b1;
        in_valid = 1'b1;
        state_in = '0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL key_load_blocks_ready: got %0b, want 0", in_ready);
        end
        tick();
        key_load = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || state_out !== rk_tab[i] || round_out !== 4'(i) || last_out !== (i == 10)) begin
                fails++;
                $display("FAIL fips_beat%0d: got v=%0b s=%h rnd=%0d l=%0b, want v=1 s=%h rnd=%0d l=%0b",
                         i, out_valid, state_out, round_out, last_out, rk_tab[i], i, (i == 10));
            end
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || state_out !== rk_tab[0] || round_out !== 4'd0 || last_out !== 1'b0) begin
            fails++;
            $display("FAIL wrap_beat: got v=%0b s=%h rnd=%0d l=%0b, want v=1 s=%h rnd=0 l=0",
                     out_valid, state_out, round_out, last_out, rk_tab[0]);
        end
        in_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_idle: got out_valid=%0b, want 0", out_valid);
        end
    endtask

    // Schedule sits at round 1 after the wrap beat.
    task automatic test_backpressure();
        in_valid = 1'b1;
        state_in = pat1;
        tick();
        tests++;
        if (state_out !== (pat1 ^ rk_tab[1]) || round_out !== 4'd1) begin
            fails++;
            $display("FAIL bp_first: got s=%h rnd=%0d, want s=%h rnd=1", state_out, round_out, pat1 ^ rk_tab[1]);
        end
        out_ready = 1'b0;
        state_in  = pat2;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== (pat1 ^ rk_tab[1]) || round_out !== 4'd1) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%0b rdy=%0b s=%h rnd=%0d, want v=1 rdy=0 s=%h rnd=1",
                         c, out_valid, in_ready, state_out, round_out, pat1 ^ rk_tab[1]);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: got %0b, want 1", in_ready);
        end
        tick();
        tests++;
        if (state_out !== (pat2 ^ rk_tab[2]) || round_out !== 4'd2) begin
            fails++;
            $display("FAIL bp_next_round: got s=%h rnd=%0d, want s=%h rnd=2", state_out, round_out, pat2 ^ rk_tab[2]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    // Schedule sits at round 3 here.
    task automatic test_key_load_collision();
        in_valid = 1'b1;
        state_in = '0;
        for (int r = 3; r <= 4; r++) begin
            tick();
            tests++;
            if (state_out !== rk_tab[r] || round_out !== 4'(r)) begin
                fails++;
                $display("FAIL coll_pre%0d: got s=%h rnd=%0d, want s=%h rnd=%0d", r, state_out, round_out, rk_tab[r], r);
            end
        end
        key_load = 1'b1;
        key_in   = key2;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL coll_ready: got %0b, want 0", in_ready);
        end
        tick();
        key_load = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL coll_no_accept: got out_valid=%0b, want 0", out_valid);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || state_out !== key2 || round_out !== 4'd0) begin
            fails++;
            $display("FAIL coll_new_key: got v=%0b s=%h rnd=%0d, want v=1 s=%h rnd=0", out_valid, state_out, round_out, key2);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, in_ready, last_out, round_out, state_out} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got v=%0b r=%0b l=%0b rnd=%0d s=%h, want all zero",
                     out_valid, in_ready, last_out, round_out, state_out);
        end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_key: got in_ready=%0b out_valid=%0b, want 0 0", in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

`ifdef ADD_ROUND_KEY_BYPASS_EN
    task automatic test_bypass();
        load_key(rk_tab[0]);
        in_valid = 1'b1;
        state_in = '0;
        for (int r = 0; r < 3; r++) tick();
        tests++;
        if (state_out !== rk_tab[2] || round_out !== 4'd2) begin
            fails++;
            $display("FAIL byp_pre: got s=%h rnd=%0d, want s=%h rnd=2", state_out, round_out, rk_tab[2]);
        end
        bypass   = 1'b1;
        state_in = pat1;
        tick();
        tests++;
        if (state_out !== pat1 || round_out !== 4'd3 || last_out !== 1'b0) begin
            fails++;
            $display("FAIL byp_pass: got s=%h rnd=%0d l=%0b, want s=%h rnd=3 l=0", state_out, round_out, last_out, pat1);
        end
        bypass   = 1'b0;
        state_in = '0;
        tick();
        tests++;
        if (state_out !== rk_tab[3] || round_out !== 4'd3) begin
            fails++;
            $display("FAIL byp_after: got s=%h rnd=%0d, want s=%h rnd=3", state_out, round_out, rk_tab[3]);
        end
        in_valid = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rk_tab[0]  = fb(128'h2b7e151628aed2a6abf7158809cf4f3c);
        rk_tab[1]  = fb(128'ha0fafe1788542cb123a339392a6c7605);
        rk_tab[2]  = fb(128'hf2c295f27a96b9435935807a7359f67f);
        rk_tab[3]  = fb(128'h3d80477d4716fe3e1e237e446d7a883b);
        rk_tab[4]  = fb(128'hef44a541a8525b7fb671253bdb0bad00);
        rk_tab[5]  = fb(128'hd4d1c6f87c839d87caf2b8bc11f915bc);
        rk_tab[6]  = fb(128'h6d88a37a110b3efddbf98641ca0093fd);
        rk_tab[7]  = fb(128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
        rk_tab[8]  = fb(128'head27321b58dbad2312bf5607f8d292f);
        rk_tab[9]  = fb(128'hac7766f319fadc2128d12941575c006e);
        rk_tab[10] = fb(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        key2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        pat1 = 128'h00112233445566778899aabbccddeeff;
        pat2 = 128'hdeadbeefcafef00d0123456789abcdef;

        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        state_in  = '0;
        out_ready = 1'b1;
`ifdef ADD_ROUND_KEY_BYPASS_EN
        bypass    = 1'b0;
`endif

        test_reset();
        test_fips_schedule();
        test_backpressure();
        test_key_load_collision();
        test_reset_midstream();
`ifdef ADD_ROUND_KEY_BYPASS_EN
        test_bypass();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
